// File: rtl/move_list_ctrl_pkg.sv
// Shared types and bounds for the move-list sequencer and its RAM walkers.
package move_list_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitGen,
    StFetch,
    StPresent,
    StClear,
    StWaitIdle,
    StDone
  } state_e;

  localparam int unsigned RamLatMin   = 1;
  localparam int unsigned RamLatMax   = 7;
  localparam int unsigned LatCntWidth = $clog2(RamLatMax + 1);

endpackage

// File: rtl/rd_lat_counter.sv
// Down-counter that covers a fixed RAM read latency; expired is high once the
// loaded latency has fully elapsed and stays high until the next load.
module rd_lat_counter #(
  parameter int unsigned LAT       = 2,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_WIDTH'(LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/move_list_ctrl.sv
// Runs one all_moves job: launch, wait for generation, stream every move over
// valid/ready, then clear the generator and wait for it to go idle.
module move_list_ctrl
  import move_list_ctrl_pkg::*;
#(
  parameter int unsigned MAX_POSITIONS_LOG2 = 7,
  parameter int unsigned EVAL_WIDTH         = 22,
  parameter int unsigned UCI_WIDTH          = 16,
  parameter int unsigned RAM_LAT            = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_in,
  input  logic                          capture_only_in,
  input  logic                          abort_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [MAX_POSITIONS_LOG2-1:0] move_count_out,
  output logic                          mate_out,
  output logic                          stalemate_out,
  output logic                          am_board_valid_out,
  output logic                          am_capture_moves_out,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index_out,
  output logic                          am_clear_moves_out,
  input  logic                          am_idle_in,
  input  logic                          am_moves_ready_in,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count_in,
  input  logic                          am_initial_mate_in,
  input  logic                          am_initial_stalemate_in,
  input  logic signed [EVAL_WIDTH-1:0]  am_eval_in,
  input  logic [UCI_WIDTH-1:0]          am_uci_in,
  output logic                          mv_valid_out,
  input  logic                          mv_ready_in,
  output logic [MAX_POSITIONS_LOG2-1:0] mv_index_out,
  output logic signed [EVAL_WIDTH-1:0]  mv_eval_out,
  output logic [UCI_WIDTH-1:0]          mv_uci_out,
  output logic                          mv_last_out
);

  localparam int unsigned W   = MAX_POSITIONS_LOG2;
  // Out-of-range latencies are clamped so the counter width stays valid.
  localparam int unsigned Lat = (RAM_LAT < RamLatMin) ? RamLatMin :
                                (RAM_LAT > RamLatMax) ? RamLatMax : RAM_LAT;

  state_e                       state_q, state_d;
  logic [W-1:0]                 index_q, index_d;
  logic [W-1:0]                 count_q;
  logic                         mate_q, stale_q, capture_q;
  logic signed [EVAL_WIDTH-1:0] eval_q;
  logic [UCI_WIDTH-1:0]         uci_q;
  logic                         latch_start, latch_result, capture_data, load_lat, lat_expired;
  logic                         is_last;

  rd_lat_counter #(
    .LAT      (Lat),
    .CNT_WIDTH(LatCntWidth)
  ) u_rd_lat (
    .clk    (clk),
    .reset  (reset),
    .load   (load_lat),
    .expired(lat_expired)
  );

  assign is_last = (index_q == count_q - W'(1));

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    latch_start  = 1'b0;
    latch_result = 1'b0;
    capture_data = 1'b0;
    load_lat     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          latch_start = 1'b1;
          state_d     = StLaunch;
        end
      end
      StLaunch: state_d = StWaitGen;
      // abort is deliberately not honoured here: the generator must finish first
      StWaitGen: begin
        if (am_moves_ready_in) begin
          latch_result = 1'b1;
          if (am_move_count_in == '0) begin
            state_d = StClear;
          end else begin
            index_d  = '0;
            load_lat = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StFetch: begin
        if (abort_in) begin
          state_d = StClear;
        end else if (lat_expired) begin
          capture_data = 1'b1;
          state_d      = StPresent;
        end
      end
      StPresent: begin
        if (abort_in) begin
          state_d = StClear;
        end else if (mv_ready_in) begin
          if (is_last) begin
            state_d = StClear;
          end else begin
            index_d  = index_q + W'(1);
            load_lat = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StClear:    state_d = StWaitIdle;
      StWaitIdle: if (am_idle_in) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      index_q   <= '0;
      count_q   <= '0;
      mate_q    <= 1'b0;
      stale_q   <= 1'b0;
      capture_q <= 1'b0;
      eval_q    <= '0;
      uci_q     <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (latch_start) capture_q <= capture_only_in;
      if (latch_result) begin
        count_q <= am_move_count_in;
        mate_q  <= am_initial_mate_in;
        stale_q <= am_initial_stalemate_in;
      end
      if (capture_data) begin
        eval_q <= am_eval_in;
        uci_q  <= am_uci_in;
      end
    end
  end

  assign busy_out             = (state_q != StIdle);
  assign done_out             = (state_q == StDone);
  assign move_count_out       = count_q;
  assign mate_out             = mate_q;
  assign stalemate_out        = stale_q;
  assign am_board_valid_out   = (state_q == StLaunch);
  assign am_capture_moves_out = capture_q;
  assign am_move_index_out    = index_q;
  assign am_clear_moves_out   = (state_q == StClear);
  assign mv_valid_out         = (state_q == StPresent);
  assign mv_index_out         = index_q;
  assign mv_eval_out          = eval_q;
  assign mv_uci_out           = uci_q;
  assign mv_last_out          = is_last;

endmodule
